rowwise_scheduler: RTL and testbench

ROWWISE_SCHEDULER -- requirements
Module: rowwise_scheduler

---
 rtl/config_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 25 ++
 rtl/rowwise_scheduler.sv | 175 +++++++++++++++++
 tb/tb_rowwise_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared types and timing constants for the rowwise FU scheduler.
// D is the nominal FU latency in RUN cycles.
package config_pkg;

  localparam int unsigned D = 4;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_RUN      = 2'd2;
  localparam logic [1:0] S_COMPLETE = 2'd3;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_MAX = 2'd3
  } operation_t;

  typedef enum logic [1:0] {
    IDLE     = S_IDLE,
    ISSUE    = S_ISSUE,
    RUN      = S_RUN,
    COMPLETE = S_COMPLETE
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above
// ptr_i, wrapping to the lowest requester when none is found above.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o
);

  logic [N-1:0] masked;
  logic [N-1:0] cand;

  always_comb begin
    masked = '0;
    for (int i = 0; i < int'(N); i++) begin
      masked[i] = req_i[i] && (i >= int'(ptr_i));
    end
    cand    = (|masked) ? masked : req_i;
    // isolate the lowest set bit
    grant_o = cand & (~cand + {{(N-1){1'b0}}, 1'b1});
  end

endmodule

// File: rtl/rowwise_scheduler.sv
// Shares one rowwise FU among NUM_REQ requesters: IDLE -> ISSUE -> RUN -> COMPLETE.
// Optional RUN watchdog with error_o when ROWWISE_SCHED_WATCHDOG_EN is defined.
//
// state    | meaning
// IDLE     | arbitrate, accept at most one command and latch it
// ISSUE    | present fu_in_valid_o until the FU takes the command
// RUN      | wait for FU completion (fu_in_ready_i), first cycle ignored
// COMPLETE | pulse done_o to the owner, advance the round-robin pointer
module rowwise_scheduler
  import config_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned BANK_W  = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  operation_t [NUM_REQ-1:0]       req_op_i,
  input  logic [NUM_REQ-1:0][BANK_W-1:0] req_src1_i,
  input  logic [NUM_REQ-1:0][BANK_W-1:0] req_src2_i,
  input  logic [NUM_REQ-1:0][BANK_W-1:0] req_dst_i,
  output logic [NUM_REQ-1:0]             done_o,
  output logic                           fu_in_valid_o,
  input  logic                           fu_in_ready_i,
  output operation_t                     fu_operation_o,
  output logic [BANK_W-1:0]              src1_sel_o,
  output logic [BANK_W-1:0]              src2_sel_o,
  output logic [BANK_W-1:0]              dst_sel_o,
`ifdef ROWWISE_SCHED_WATCHDOG_EN
  output logic                           error_o,
`endif
  output logic                           busy_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t      state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  idx_q, idx_d;
  operation_t        op_q, op_d;
  logic [BANK_W-1:0] src1_q, src1_d;
  logic [BANK_W-1:0] src2_q, src2_d;
  logic [BANK_W-1:0] dst_q, dst_d;
  logic              first_q, first_d;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   nxt_ptr;

`ifdef ROWWISE_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(2 * D + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(2 * D);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign nxt_ptr = (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    op_d     = op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    dst_d    = dst_q;
    first_d  = first_q;
`ifdef ROWWISE_SCHED_WATCHDOG_EN
    wd_d     = wd_q;
    error_o  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          idx_d   = gnt_idx;
          op_d    = req_op_i[gnt_idx];
          src1_d  = req_src1_i[gnt_idx];
          src2_d  = req_src2_i[gnt_idx];
          dst_d   = req_dst_i[gnt_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (fu_in_ready_i) begin
          state_d = RUN;
          first_d = 1'b1;
`ifdef ROWWISE_SCHED_WATCHDOG_EN
          wd_d    = WD_LOAD;
`endif
        end
      end
      RUN: begin
        first_d = 1'b0;
        // fu_in_ready_i in the first RUN cycle is the tail of the start handshake
        if (!first_q && fu_in_ready_i) begin
          state_d = COMPLETE;
        end
`ifdef ROWWISE_SCHED_WATCHDOG_EN
        else if (wd_q == '0) begin
          error_o  = 1'b1;
          rr_ptr_d = nxt_ptr;
          state_d  = IDLE;
        end else begin
          wd_d = wd_q - 1'b1;
        end
`endif
      end
      COMPLETE: begin
        rr_ptr_d = nxt_ptr;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      op_q     <= OP_ADD;
      src1_q   <= '0;
      src2_q   <= '0;
      dst_q    <= '0;
      first_q  <= 1'b0;
`ifdef ROWWISE_SCHED_WATCHDOG_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      dst_q    <= dst_d;
      first_q  <= first_d;
`ifdef ROWWISE_SCHED_WATCHDOG_EN
      wd_q     <= wd_d;
`endif
    end
  end

  // grant is combinational from req_valid_i, so it must be masked during reset
  assign req_ready_o = (state_q == IDLE && !rst_i) ? grant : '0;

  always_comb begin
    done_o = '0;
    if (state_q == COMPLETE) done_o[idx_q] = 1'b1;
  end

  assign fu_in_valid_o  = (state_q == ISSUE);
  assign busy_o         = (state_q != IDLE);
  assign fu_operation_o = op_q;
  assign src1_sel_o     = src1_q;
  assign src2_sel_o     = src2_q;
  assign dst_sel_o      = dst_q;

endmodule

// File: tb/tb_rowwise_scheduler.sv
// Self-checking bench for rowwise_scheduler with a D-cycle FU model and a
// grant/done scoreboard. Watchdog scenario runs when ROWWISE_SCHED_WATCHDOG_EN is defined.
module tb_rowwise_scheduler;
  import config_pkg::*;

  localparam int N  = 4;
  localparam int BW = 3;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N-1:0]           req_valid = '0;
  logic [N-1:0]           req_ready_o;
  operation_t [N-1:0]     req_op;
  logic [N-1:0][BW-1:0]   req_src1, req_src2, req_dst;
  logic [N-1:0]           done_o;
  logic                   fu_in_valid_o;
  logic                   fu_ready = 1'b0;
  operation_t             fu_operation_o;
  logic [BW-1:0]          src1_sel_o, src2_sel_o, dst_sel_o;
  logic                   busy_o;
`ifdef ROWWISE_SCHED_WATCHDOG_EN
  logic                   error_o;
`endif

  rowwise_scheduler #(.NUM_REQ(N), .BANK_W(BW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready_o),
    .req_op_i       (req_op),
    .req_src1_i     (req_src1),
    .req_src2_i     (req_src2),
    .req_dst_i      (req_dst),
    .done_o         (done_o),
    .fu_in_valid_o  (fu_in_valid_o),
    .fu_in_ready_i  (fu_ready),
    .fu_operation_o (fu_operation_o),
    .src1_sel_o     (src1_sel_o),
    .src2_sel_o     (src2_sel_o),
    .dst_sel_o      (dst_sel_o),
`ifdef ROWWISE_SCHED_WATCHDOG_EN
    .error_o        (error_o),
`endif
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { int idx; int gcyc; } exp_t;
  exp_t sb[$];

  // FU model: accepts after stall_left ISSUE cycles, then signals completion in RUN cycle D
  int stall_left = 0;
  bit fu_hang    = 1'b0;
  bit fu_busy    = 1'b0;
  int fu_cnt     = 0;

  always @(negedge clk) begin
    if (rst) begin
      fu_busy  = 1'b0;
      fu_cnt   = 0;
      fu_ready = 1'b0;
    end else if (!fu_busy) begin
      if (fu_in_valid_o) begin
        if (stall_left > 0) begin
          stall_left--;
          fu_ready = 1'b0;
        end else begin
          fu_ready = 1'b1;
          fu_busy  = 1'b1;
          fu_cnt   = 0;
        end
      end else begin
        fu_ready = 1'b0;
      end
    end else begin
      fu_cnt++;
      fu_ready = (fu_cnt == int'(D)) && !fu_hang;
      if (!busy_o) begin
        fu_busy  = 1'b0;
        fu_ready = 1'b0;
      end
    end
  end

  task automatic set_req(input int i, input operation_t op, input int s1, input int s2, input int d);
    req_op[i]   = op;
    req_src1[i] = BW'(s1);
    req_src2[i] = BW'(s2);
    req_dst[i]  = BW'(d);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    fu_hang    = 1'b0;
    stall_left = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(output logic [N-1:0] seen, output int at, output bit timeout);
    seen    = '0;
    at      = 0;
    timeout = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      #1;
      if (done_o !== '0) begin
        seen    = done_o;
        at      = cyc;
        timeout = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst       = 1'b1;
    req_valid = '1;
    @(negedge clk);
    #1;
    n_checks++; if (req_ready_o !== '0) $display("FAIL reset_ready: got %b want 0000", req_ready_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0 || fu_in_valid_o !== 1'b0) $display("FAIL reset_busy_valid: got %b%b want 00", busy_o, fu_in_valid_o); else n_pass++;
    n_checks++; if (done_o !== '0) $display("FAIL reset_done: got %b want 0000", done_o); else n_pass++;
    n_checks++; if ({src1_sel_o, src2_sel_o, dst_sel_o, fu_operation_o} !== '0) $display("FAIL reset_regs: got %h want 0", {src1_sel_o, src2_sel_o, dst_sel_o, fu_operation_o}); else n_pass++;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    e.idx = 0;
  endtask

  task automatic test_single();
    exp_t e;
    logic [N-1:0] seen;
    int at;
    bit to;
    do_reset();
    @(negedge clk);
    set_req(0, OP_ADD, 1, 2, 3);
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready_o !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready_o); else n_pass++;
    sb.push_back('{0, cyc});
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    #1;
    n_checks++; if (fu_in_valid_o !== 1'b1) $display("FAIL single_fu_valid: got %b want 1", fu_in_valid_o); else n_pass++;
    n_checks++; if ({src1_sel_o, src2_sel_o, dst_sel_o} !== {3'd1, 3'd2, 3'd3}) $display("FAIL single_sels: got %0d/%0d/%0d want 1/2/3", src1_sel_o, src2_sel_o, dst_sel_o); else n_pass++;
    n_checks++; if (fu_operation_o !== OP_ADD) $display("FAIL single_op: got %0d want %0d", fu_operation_o, OP_ADD); else n_pass++;
    wait_done(seen, at, to);
    n_checks++;
    if (to || sb.size() == 0) $display("FAIL single_done: got timeout want done pulse");
    else begin
      e = sb.pop_front();
      if (seen !== (N'(1) << e.idx) || at - e.gcyc != int'(D) + 2)
        $display("FAIL single_done: got %b at +%0d want %b at +%0d", seen, at - e.gcyc, N'(1) << e.idx, int'(D) + 2);
      else n_pass++;
    end
    @(negedge clk);
    #1;
    n_checks++; if (done_o !== '0 || busy_o !== 1'b0) $display("FAIL single_done_width: got done %b busy %b want 0000 0", done_o, busy_o); else n_pass++;
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int ngrant = 0, ndone = 0, last_g = -1;
    bit stop = 1'b0;
    exp_t e;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, OP_SUB, i, i + 1, i + 2);
    for (int t = 0; t < 300 && ndone < 5; t++) begin
      @(negedge clk);
      req_valid = stop ? '0 : '1;
      #1;
      if (req_ready_o !== '0 && ngrant < 5) begin
        n_checks++; if (req_ready_o !== (N'(1) << order[ngrant])) $display("FAIL rr_grant%0d: got %b want %b", ngrant, req_ready_o, N'(1) << order[ngrant]); else n_pass++;
        if (last_g >= 0) begin
          n_checks++; if (cyc - last_g != int'(D) + 3) $display("FAIL rr_gap%0d: got %0d want %0d", ngrant, cyc - last_g, int'(D) + 3); else n_pass++;
        end
        sb.push_back('{order[ngrant], cyc});
        last_g = cyc;
        ngrant++;
        if (ngrant == 5) stop = 1'b1;
      end
      if (done_o !== '0) begin
        n_checks++;
        if (sb.size() == 0) $display("FAIL rr_done%0d: got %b want no pulse", ndone, done_o);
        else begin
          e = sb.pop_front();
          if (done_o !== (N'(1) << e.idx) || cyc - e.gcyc != int'(D) + 2)
            $display("FAIL rr_done%0d: got %b at +%0d want %b at +%0d", ndone, done_o, cyc - e.gcyc, N'(1) << e.idx, int'(D) + 2);
          else n_pass++;
        end
        ndone++;
      end
    end
    req_valid = '0;
    n_checks++; if (ndone != 5) $display("FAIL rr_count: got %0d dones want 5", ndone); else n_pass++;
  endtask

  task automatic test_issue_stall();
    logic [N-1:0] seen;
    int at, g;
    bit to;
    do_reset();
    stall_left = 3;
    @(negedge clk);
    set_req(1, OP_MUL, 4, 5, 6);
    req_valid = 4'b0010;
    #1;
    n_checks++; if (req_ready_o !== 4'b0010) $display("FAIL stall_ready: got %b want 0010", req_ready_o); else n_pass++;
    g = cyc;
    @(posedge clk);
    #1 req_valid = '0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      if (s == 1) begin
        set_req(3, OP_MAX, 7, 7, 0);
        req_valid = 4'b1000;
      end
      #1;
      n_checks++;
      if (fu_in_valid_o !== 1'b1 || fu_operation_o !== OP_MUL || fu_ready !== (s == 3) || req_ready_o !== '0)
        $display("FAIL stall_cycle%0d: got valid %b op %0d ready %b acc %b want 1 %0d %b 0000", s, fu_in_valid_o, fu_operation_o, fu_ready, req_ready_o, OP_MUL, s == 3);
      else n_pass++;
    end
    @(negedge clk);
    #1;
    n_checks++; if (fu_in_valid_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL stall_run: got valid %b busy %b want 0 1", fu_in_valid_o, busy_o); else n_pass++;
    wait_done(seen, at, to);
    n_checks++; if (to || seen !== 4'b0010 || at - g != int'(D) + 5) $display("FAIL stall_done: got %b at +%0d want 0010 at +%0d", seen, at - g, int'(D) + 5); else n_pass++;
    n_checks++; if (req_ready_o !== '0) $display("FAIL held_not_ready: got %b want 0000", req_ready_o); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (req_ready_o !== 4'b1000) $display("FAIL held_grant: got %b want 1000", req_ready_o); else n_pass++;
    g = cyc;
    @(posedge clk);
    #1 req_valid = '0;
    wait_done(seen, at, to);
    n_checks++; if (to || seen !== 4'b1000 || at - g != int'(D) + 2) $display("FAIL held_done: got %b at +%0d want 1000 at +%0d", seen, at - g, int'(D) + 2); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [N-1:0] seen;
    int at;
    bit to, saw_done;
    do_reset();
    @(negedge clk);
    set_req(2, OP_ADD, 7, 6, 5);
    req_valid = 4'b0100;
    #1;
    n_checks++; if (req_ready_o !== 4'b0100) $display("FAIL midrst_ready: got %b want 0100", req_ready_o); else n_pass++;
    @(posedge clk);
    #1 req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (busy_o !== 1'b1 || fu_in_valid_o !== 1'b0) $display("FAIL midrst_in_run: got busy %b valid %b want 1 0", busy_o, fu_in_valid_o); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || fu_in_valid_o !== 1'b0 || done_o !== '0 || {src1_sel_o, src2_sel_o, dst_sel_o} !== '0)
      $display("FAIL midrst_outputs: got busy %b valid %b done %b sels %h want all 0", busy_o, fu_in_valid_o, done_o, {src1_sel_o, src2_sel_o, dst_sel_o});
    else n_pass++;
    saw_done = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      #1;
      if (done_o !== '0) saw_done = 1'b1;
    end
    rst = 1'b0;
    for (int t = 0; t < int'(D) + 3; t++) begin
      @(negedge clk);
      #1;
      if (done_o !== '0 || busy_o !== 1'b0) saw_done = 1'b1;
    end
    n_checks++; if (saw_done) $display("FAIL midrst_no_done: got activity want none"); else n_pass++;
    @(negedge clk);
    set_req(0, OP_SUB, 1, 1, 1);
    req_valid = 4'b0101;
    #1;
    n_checks++; if (req_ready_o !== 4'b0001) $display("FAIL midrst_regrant: got %b want 0001", req_ready_o); else n_pass++;
    @(posedge clk);
    #1 req_valid = '0;
    wait_done(seen, at, to);
    n_checks++; if (to || seen !== 4'b0001) $display("FAIL midrst_done: got %b want 0001", seen); else n_pass++;
  endtask

  task automatic test_drop_valid();
    logic [N-1:0] seen;
    int g;
    bit unstable = 1'b0, found = 1'b0;
    do_reset();
    @(negedge clk);
    set_req(2, OP_SUB, 2, 4, 6);
    req_valid = 4'b0100;
    #1;
    n_checks++; if (req_ready_o !== 4'b0100) $display("FAIL drop_ready: got %b want 0100", req_ready_o); else n_pass++;
    g = cyc;
    @(posedge clk);
    #1;
    req_valid = '0;
    set_req(2, OP_MAX, 0, 0, 0);
    seen = '0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      #1;
      if ({src1_sel_o, src2_sel_o, dst_sel_o} !== {3'd2, 3'd4, 3'd6} || fu_operation_o !== OP_SUB) unstable = 1'b1;
      if (done_o !== '0) begin
        seen  = done_o;
        found = 1'b1;
        n_checks++; if (cyc - g != int'(D) + 2) $display("FAIL drop_latency: got +%0d want +%0d", cyc - g, int'(D) + 2); else n_pass++;
      end
    end
    n_checks++; if (unstable) $display("FAIL drop_stable: got changing sels/op want 2/4/6 SUB"); else n_pass++;
    n_checks++; if (seen !== 4'b0100) $display("FAIL drop_done: got %b want 0100", seen); else n_pass++;
  endtask

`ifdef ROWWISE_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    logic [N-1:0] seen;
    int at, g, err_at = -1;
    bit to, saw_done = 1'b0;
    do_reset();
    fu_hang = 1'b1;
    @(negedge clk);
    set_req(0, OP_MUL, 3, 3, 3);
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready_o !== 4'b0001) $display("FAIL wd_ready: got %b want 0001", req_ready_o); else n_pass++;
    g = cyc;
    @(posedge clk);
    #1 req_valid = '0;
    for (int t = 0; t < 100 && err_at < 0; t++) begin
      @(negedge clk);
      #1;
      if (done_o !== '0) saw_done = 1'b1;
      if (error_o === 1'b1) err_at = cyc;
    end
    n_checks++; if (err_at - g != 2 * int'(D) + 2) $display("FAIL wd_error_time: got +%0d want +%0d", err_at - g, 2 * int'(D) + 2); else n_pass++;
    n_checks++; if (saw_done) $display("FAIL wd_no_done: got done pulse want none"); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (busy_o !== 1'b0 || error_o !== 1'b0) $display("FAIL wd_after: got busy %b err %b want 0 0", busy_o, error_o); else n_pass++;
    fu_hang = 1'b0;
    set_req(1, OP_ADD, 1, 1, 1);
    req_valid = 4'b0011;
    #1;
    n_checks++; if (req_ready_o !== 4'b0010) $display("FAIL wd_ptr_adv: got %b want 0010", req_ready_o); else n_pass++;
    @(posedge clk);
    #1 req_valid = '0;
    wait_done(seen, at, to);
    n_checks++; if (to || seen !== 4'b0010) $display("FAIL wd_recover: got %b want 0010", seen); else n_pass++;
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) set_req(i, OP_ADD, 0, 0, 0);
    test_reset();
    test_single();
    test_round_robin();
    test_issue_stall();
    test_reset_mid_run();
    test_drop_valid();
`ifdef ROWWISE_SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
